// File: rtl/img_pkg.sv
// Shared image-pipeline constants, row/address types and the window FSM state set.
package img_pkg;

   localparam int unsigned ROW_W  = 64;
   localparam int unsigned ADDR_W = 7;
   localparam int unsigned N_ROWS = 128;

   typedef logic [ROW_W-1:0]  row_t;
   typedef logic [ADDR_W-1:0] addr_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRIME0,
      S_PRIME1,
      S_EMIT,
      S_FETCH,
      S_DONE
   } win_state_t;

endpackage

// File: rtl/rom_row_window.sv
// Streams the image ROM one row per fetch and presents a zero-padded 3-row
// sliding window (top/mid/bot) to the morphological filter with valid/ready.
module rom_row_window #(
   parameter int unsigned      ROW_W   = 64,
   parameter int unsigned      ADDR_W  = 7,
   parameter int unsigned      N_ROWS  = 128,
   parameter logic [ROW_W-1:0] PAD_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              rom_rd_req,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [ROW_W-1:0]  rom_data,
   output logic              win_valid,
   input  logic              win_ready,
   output logic [ROW_W-1:0]  win_top,
   output logic [ROW_W-1:0]  win_mid,
   output logic [ROW_W-1:0]  win_bot,
   output logic [ADDR_W-1:0] win_row
);

   import img_pkg::*;

   // Last row index, at both the counter width and the widened compare width.
   localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(N_ROWS - 1);
   localparam logic [ADDR_W:0]   LAST_ROWW = (ADDR_W+1)'(N_ROWS - 1);

   win_state_t          r_state;
   logic                r_busy;
   logic                r_done;
   logic                r_rd_req;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_valid;
   logic [ROW_W-1:0]    r_top;
   logic [ROW_W-1:0]    r_mid;
   logic [ROW_W-1:0]    r_bot;
   logic [ADDR_W-1:0]   r_row;

   // row+2 carried one bit wider so the look-ahead never wraps at N_ROWS = 2**ADDR_W.
   logic [ADDR_W:0]     w_row_p2;

   assign w_row_p2 = {1'b0, r_row} + (ADDR_W+1)'(2);

   // Window FSM; every output is registered alongside the state it belongs to,
   // so the ROM request/address are set up on the transition into PRIME/FETCH.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_rd_req <= 1'b0;
         r_addr   <= '0;
         r_valid  <= 1'b0;
         r_top    <= '0;
         r_mid    <= '0;
         r_bot    <= '0;
         r_row    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state  <= S_PRIME0;
                  r_busy   <= 1'b1;
                  r_rd_req <= 1'b1;
                  r_addr   <= '0;
               end
            end

            S_PRIME0: begin
               r_mid    <= rom_data;
               r_top    <= PAD_VAL;
               r_row    <= '0;
               r_state  <= S_PRIME1;
               r_rd_req <= 1'b1;
               r_addr   <= ADDR_W'(1);
            end

            S_PRIME1: begin
               r_bot    <= rom_data;
               r_state  <= S_EMIT;
               r_rd_req <= 1'b0;
               r_addr   <= '0;
               r_valid  <= 1'b1;
            end

            S_EMIT: begin
               if (win_ready) begin
                  r_valid <= 1'b0;
                  if (r_row == LAST_ROW) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_FETCH;
                     // Past the last row the next bot is padding, so no ROM read is issued.
                     if (w_row_p2 <= LAST_ROWW) begin
                        r_rd_req <= 1'b1;
                        r_addr   <= w_row_p2[ADDR_W-1:0];
                     end
                  end
               end
            end

            S_FETCH: begin
               r_top    <= r_mid;
               r_mid    <= r_bot;
               r_bot    <= r_rd_req ? rom_data : PAD_VAL;
               r_row    <= r_row + ADDR_W'(1);
               r_state  <= S_EMIT;
               r_rd_req <= 1'b0;
               r_addr   <= '0;
               r_valid  <= 1'b1;
            end

            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               r_state  <= S_IDLE;
               r_busy   <= 1'b0;
               r_done   <= 1'b0;
               r_rd_req <= 1'b0;
               r_addr   <= '0;
               r_valid  <= 1'b0;
            end
         endcase
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign rom_rd_req = r_rd_req;
   assign rom_addr   = r_addr;
   assign win_valid  = r_valid;
   assign win_top    = r_top;
   assign win_mid    = r_mid;
   assign win_bot    = r_bot;
   assign win_row    = r_row;

endmodule
